// File: rtl/traffic_pkg.sv
// Shared light encodings, FSM state type and round-robin helper for the traffic phase sequencer.
package traffic_pkg;

    localparam logic [2:0] LT_RED = 3'b100;
    localparam logic [2:0] LT_YEL = 3'b010;
    localparam logic [2:0] LT_GRN = 3'b001;

    // Widest request vector rr_pick can search.
    localparam int unsigned MAX_ROADS = 32;

    typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALL_RED} state_e;

    // First set bit of vec searching cur+1, cur+2, ... with wrap at n; cur if none set.
    function automatic int unsigned rr_pick(input logic [MAX_ROADS-1:0] vec,
                                            input int unsigned n,
                                            input int unsigned cur);
        int unsigned idx;
        int unsigned pick;
        logic found;
        pick  = cur;
        found = 1'b0;
        for (int unsigned k = 1; k <= MAX_ROADS; k++) begin
            idx = cur + k;
            if (idx >= n) idx = idx - n;
            if (!found && k <= n && vec[idx[4:0]]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/tlc_tick_gen.sv
// Timing prescaler: one-cycle tick every TICK_DIV clocks, restartable from zero via clr.
module tlc_tick_gen #(
    parameter int unsigned TICK_DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick = (cnt_q == CW'(TICK_DIV - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr || tick) cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// N-approach traffic signal sequencer: main road rests on green, side roads served round-robin
// on latched requests, with gap-out/max-out extension, all-red clearance and emergency preemption.
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int unsigned N_ROADS     = 4,
    parameter int unsigned MAIN_ROAD   = 0,
    parameter int unsigned TICK_DIV    = 2,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned T_MIN_GREEN = 4,
    parameter int unsigned T_MAX_GREEN = 10,
    parameter int unsigned T_YELLOW    = 3,
    parameter int unsigned T_ALL_RED   = 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [N_ROADS-1:0]         sensor,
    input  logic                       emerg_req,
    input  logic [$clog2(N_ROADS)-1:0] emerg_road,
    output logic [3*N_ROADS-1:0]       lights,
    output logic [$clog2(N_ROADS)-1:0] active_road,
    output logic [N_ROADS-1:0]         req_pending
);

    localparam int unsigned RW = $clog2(N_ROADS);

    state_e             state_q, state_d;
    logic [RW-1:0]      cur_q, cur_d, nxt_q, nxt_d, rr_nxt;
    logic [CNT_W-1:0]   timer_q, timer_d, elapsed;
    logic [N_ROADS-1:0] req_q, req_d, cur_oh, pend_other, set_mask;
    logic               tick, state_chg, emerg_valid;

    tlc_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .clr   (state_chg),
        .tick  (tick)
    );

    // Timer value including this cycle's tick, so every state lasts exactly T*TICK_DIV clocks.
    assign elapsed     = (tick && timer_q != '1) ? timer_q + 1'b1 : timer_q;
    assign emerg_valid = emerg_req && (32'(emerg_road) < N_ROADS);
    assign state_chg   = (state_d != state_q);

    always_comb begin
        cur_oh        = '0;
        cur_oh[cur_q] = 1'b1;
        pend_other    = req_q & ~cur_oh;
        if (cur_q != RW'(MAIN_ROAD)) pend_other[MAIN_ROAD] = 1'b1;
    end

    assign rr_nxt = RW'(rr_pick(MAX_ROADS'(pend_other), N_ROADS, 32'(cur_q)));

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        nxt_d   = nxt_q;
        unique case (state_q)
            S_GREEN: begin
                if (emerg_valid) begin
                    if (emerg_road != cur_q) begin
                        state_d = S_YELLOW;
                        nxt_d   = emerg_road;
                    end
                end else if (elapsed >= CNT_W'(T_MIN_GREEN) && |pend_other &&
                             (!sensor[cur_q] || elapsed >= CNT_W'(T_MAX_GREEN))) begin
                    state_d = S_YELLOW;
                    nxt_d   = rr_nxt;
                end
            end
            S_YELLOW: begin
                if (emerg_valid) nxt_d = emerg_road;
                if (elapsed >= CNT_W'(T_YELLOW)) begin
                    if (T_ALL_RED == 0) begin
                        state_d = S_GREEN;
                        cur_d   = nxt_d;
                    end else begin
                        state_d = S_ALL_RED;
                    end
                end
            end
            S_ALL_RED: begin
                if (emerg_valid) nxt_d = emerg_road;
                if (elapsed >= CNT_W'(T_ALL_RED)) begin
                    state_d = S_GREEN;
                    cur_d   = nxt_d;
                end
            end
            default: state_d = S_GREEN;
        endcase
    end

    // A sensor on the road already holding green is not latched; entering green clears its own bit.
    always_comb begin
        set_mask = sensor & ~((state_q == S_GREEN) ? cur_oh : '0);
        req_d    = req_q | set_mask;
        if (state_chg && state_d == S_GREEN) req_d[cur_d] = 1'b0;
        timer_d = state_chg ? '0 : elapsed;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_GREEN;
            cur_q   <= RW'(MAIN_ROAD);
            nxt_q   <= RW'(MAIN_ROAD);
            timer_q <= '0;
            req_q   <= '0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            nxt_q   <= nxt_d;
            timer_q <= timer_d;
            req_q   <= req_d;
        end
    end

    for (genvar i = 0; i < N_ROADS; i++) begin : g_lamp
        assign lights[3*i +: 3] = (cur_q != RW'(i))      ? LT_RED :
                                  (state_q == S_GREEN)  ? LT_GRN :
                                  (state_q == S_YELLOW) ? LT_YEL : LT_RED;
    end

    assign active_road = cur_q;
    assign req_pending = req_q;

endmodule
